uart_cmd_parser: RTL

Frame decoder between the UART receiver's byte stream and the diff_freq_serial_out bank. It assembles framed command packets (header, channel, pattern, control, checksum), validates them, and presents one command per valid/ready handshake. It returns an ACK or NAK byte through the UART transmitter, replacing the raw loopback echo. Inter-byte timeouts and protocol errors are counted.

---
 rtl/uart_cmd_parser_pkg.sv | 27 ++
 rtl/uart_byte_timer.sv | 35 +++
 rtl/uart_cmd_parser.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_pkg: shared constants and types for the UART command parser.
//   HEADER    - first byte of every command frame
//   ACK / NAK - response bytes returned through the UART transmitter
//   state_t   - parser FSM states
//   frame_len - total frame length in bytes for a given pattern width
package uart_cmd_pkg;

  localparam logic [7:0] HEADER = 8'hA5;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    CHAN,
    DATA,
    CTRL,
    CHECK,
    OUT,
    RESP
  } state_t;

  // Header, channel, control and checksum plus one byte per pattern octet.
  function automatic int frame_len(input int data_bit);
    return data_bit / 8 + 4;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// uart_byte_timer: reloadable inter-byte timeout counter.
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   enable  in  1  count only while a frame is partially received
//   reload  in  1  byte strobe; restarts the idle interval
//   expired out 1  combinational pulse in the cycle whose clock edge is the
//                  TIMEOUT_CYC-th edge after the last reload
module uart_byte_timer #(
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  // A reload in the expiry cycle suppresses the pulse, so a late byte wins.
  assign expired = enable && !reload && (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || reload || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles framed command packets from the UART receiver,
// validates them, hands one command per valid/ready handshake to the serial
// output bank and answers each checked frame with ACK or NAK.
//   clk_i          in   1         system clock
//   rst_ni         in   1         asynchronous active-low reset
//   data_i         in   8         received byte, valid with rx_done_tick_i
//   rx_done_tick_i in   1         byte-received strobe
//   cmd_valid_o    out  1         decoded command available
//   cmd_ready_i    in   1         consumer accepts the command
//   cmd_channel_o  out  CH_W      target output index
//   cmd_pattern_o  out  DATA_BIT  output pattern
//   cmd_ctrl_o     out  8         control byte
//   tx_start_o     out  1         one-cycle strobe to the UART transmitter
//   tx_data_o      out  8         response byte
//   tx_done_tick_i in   1         transmitter finished the byte
//   err_count_o    out  8         saturating error counter
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter  int DATA_BIT    = 32,
  parameter  int OUTPUT_NUM  = 16,
  parameter  int TIMEOUT_CYC = 100_000,
  localparam int CH_W        = $clog2(OUTPUT_NUM)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [CH_W-1:0]     cmd_channel_o,
  output logic [DATA_BIT-1:0] cmd_pattern_o,
  output logic [7:0]          cmd_ctrl_o,
  output logic                tx_start_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_done_tick_i,
  output logic [7:0]          err_count_o
);

  localparam int               N_BYTES  = frame_len(DATA_BIT) - 4;
  localparam int               IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [8:0]       CH_LIMIT = 9'(OUTPUT_NUM);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          ch_byte;
  logic [7:0]          ctrl_byte;
  logic [7:0]          chk;
  logic [DATA_BIT-1:0] pattern;
  logic                timer_en;
  logic                expired;
  logic                frame_ok;
  logic                err_inc;

  assign timer_en = (state == CHAN) || (state == DATA) ||
                    (state == CTRL) || (state == CHECK);

  // The full channel byte is range-checked so out-of-range values never alias.
  assign frame_ok = (data_i == chk) && ({1'b0, ch_byte} < CH_LIMIT);

  // Exactly one error source can be active per cycle: a byte during OUT/RESP,
  // a rejected checksum byte, or an expiry that no byte overrode.
  always_comb begin
    err_inc = 1'b0;
    if (rx_done_tick_i) begin
      if (state == OUT || state == RESP) begin
        err_inc = 1'b1;
      end else if (state == CHECK && !frame_ok) begin
        err_inc = 1'b1;
      end
    end else if (expired) begin
      err_inc = 1'b1;
    end
  end

  uart_byte_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .enable (timer_en),
    .reload (rx_done_tick_i),
    .expired(expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      idx           <= '0;
      ch_byte       <= '0;
      ctrl_byte     <= '0;
      chk           <= '0;
      pattern       <= '0;
      cmd_valid_o   <= 1'b0;
      cmd_channel_o <= '0;
      cmd_pattern_o <= '0;
      cmd_ctrl_o    <= '0;
      tx_start_o    <= 1'b0;
      tx_data_o     <= '0;
      err_count_o   <= '0;
    end else begin
      tx_start_o <= 1'b0;
      if (err_inc && err_count_o != 8'hFF) begin
        err_count_o <= err_count_o + 8'd1;
      end
      case (state)
        IDLE: begin
          if (rx_done_tick_i && data_i == HEADER) begin
            state <= CHAN;
          end
        end
        CHAN: begin
          if (rx_done_tick_i) begin
            ch_byte <= data_i;
            chk     <= data_i;
            idx     <= '0;
            state   <= DATA;
          end else if (expired) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (rx_done_tick_i) begin
            pattern[{idx, 3'b000} +: 8] <= data_i;
            chk <= chk ^ data_i;
            if (idx == LAST_IDX) begin
              state <= CTRL;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (expired) begin
            state <= IDLE;
          end
        end
        CTRL: begin
          if (rx_done_tick_i) begin
            ctrl_byte <= data_i;
            chk       <= chk ^ data_i;
            state     <= CHECK;
          end else if (expired) begin
            state <= IDLE;
          end
        end
        CHECK: begin
          if (rx_done_tick_i) begin
            if (frame_ok) begin
              // Payload is copied only here, while cmd_valid_o is still low.
              cmd_channel_o <= ch_byte[CH_W-1:0];
              cmd_pattern_o <= pattern;
              cmd_ctrl_o    <= ctrl_byte;
              cmd_valid_o   <= 1'b1;
              state         <= OUT;
            end else begin
              tx_data_o  <= NAK;
              tx_start_o <= 1'b1;
              state      <= RESP;
            end
          end else if (expired) begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            tx_data_o   <= ACK;
            tx_start_o  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (tx_done_tick_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
